// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory burst DMA: FSM states, latched command
// and the per-beat byte-count helper.
package mem_dma_pkg;

  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 16;
  localparam int BEAT_BYTES = 16;
  localparam int DATA_W     = 8 * BEAT_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              write;
  } dma_cmd_t;

  // Bytes carried by the next beat: a full beat, or whatever remains.
  function automatic logic [4:0] beat_ctrl(input logic [LEN_W-1:0] rem);
    return (rem >= LEN_W'(BEAT_BYTES)) ? 5'(BEAT_BYTES) : rem[4:0];
  endfunction

endpackage

// File: rtl/mem_dma_out_reg.sv
// Single-entry valid/ready holding register for read beats; a load is only
// requested by the parent when the entry is empty or draining this cycle.
module mem_dma_out_reg
  import mem_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [4:0]        i_bytes,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [4:0]        o_bytes,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_bytes;
  logic              r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_bytes <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_bytes <= i_bytes;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_bytes = r_bytes;
  assign o_last  = r_last;

endmodule

// File: rtl/mem_burst_dma.sv
// Burst master: splits one (addr, len, dir) command into <=16-byte beats on the
// memory port, streaming read beats out and write beats in over valid/ready.
module mem_burst_dma
  import mem_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [4:0]        rd_bytes,
  output logic              rd_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              interface_en,
  output logic              interface_rdwr,
  output logic [ADDR_W-1:0] interface_addr,
  output logic [4:0]        interface_control,
  output logic [DATA_W-1:0] interface_wr_data,
  input  logic [DATA_W-1:0] interface_rd_data
);

  dma_state_t        r_state;
  dma_cmd_t          r_cmd;
  logic [4:0]        w_ctrl;
  logic              w_out_valid;
  logic              w_rd_issue;
  logic              w_wr_hs;
  logic              w_beat;
  logic [DATA_W-1:0] w_rd_masked;

  assign w_ctrl = beat_ctrl(r_cmd.len);

  // A read beat is issued only when the output register can take it this edge.
  assign w_rd_issue = (r_state == RD) && (r_cmd.len != '0) && (!w_out_valid || rd_ready);
  assign wr_ready   = (r_state == WR) && (r_cmd.len != '0);
  assign w_wr_hs    = wr_ready && wr_valid;
  assign w_beat     = w_rd_issue || w_wr_hs;

  assign interface_en      = w_beat;
  assign interface_rdwr    = w_beat && r_cmd.write;
  assign interface_addr    = w_beat ? r_cmd.addr : '0;
  assign interface_control = w_beat ? w_ctrl : '0;
  assign interface_wr_data = w_wr_hs ? wr_data : '0;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state == RD) || (r_state == WR);
  assign done      = (r_state == FIN);

  genvar gi;
  generate
    for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_mask
      assign w_rd_masked[8*gi +: 8] = (5'(gi) < w_ctrl) ? interface_rd_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (cmd_valid) begin
          r_cmd <= '{addr: cmd_addr, len: cmd_len, write: cmd_write};
          if (cmd_len == '0)  r_state <= FIN;
          else if (cmd_write) r_state <= WR;
          else                r_state <= RD;
        end
        RD:  if ((r_cmd.len == '0) && w_out_valid && rd_ready) r_state <= FIN;
        WR:  if (w_wr_hs && (r_cmd.len == LEN_W'(w_ctrl)))     r_state <= FIN;
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_beat) begin
        r_cmd.addr <= r_cmd.addr + ADDR_W'(w_ctrl);
        r_cmd.len  <= r_cmd.len - LEN_W'(w_ctrl);
      end
    end
  end

  mem_dma_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_rd_issue),
    .i_data  (w_rd_masked),
    .i_bytes (w_ctrl),
    .i_last  (r_cmd.len == LEN_W'(w_ctrl)),
    .i_ready (rd_ready),
    .o_valid (w_out_valid),
    .o_data  (rd_data),
    .o_bytes (rd_bytes),
    .o_last  (rd_last)
  );

  assign rd_valid = w_out_valid;

endmodule
